dmem_mmio_arbiter: RTL

Shares the single data-memory/MMIO slave port between two masters: the CPU pipeline's memory stage (M0) and the PDU debug port (M1). Each cycle it grants at most one request, decodes the address to data memory or the MMIO register block, and returns the read data or write acknowledge exactly one cycle after the grant. It sits between the masters and the existing DMEM/MMIO slaves and gives the CPU a stall signal while it waits.

---
 rtl/mem_bus_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/dmem_mmio_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory/MMIO bus: widths, master ids,
// MMIO window decode and the response record.
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [15:0] MMIO_BASE_HI_DEF = 16'hFFFF;

    typedef enum logic {
        M0_CPU = 1'b0,
        M1_PDU = 1'b1
    } master_e;

    localparam int unsigned RSP_ID_W = $bits(master_e);

    typedef struct packed {
        logic    v;
        master_e id;
        logic    mmio;
        logic    we;
    } rsp_t;

    function automatic logic is_mmio(input logic [ADDR_W-1:0] addr,
                                     input logic [15:0]       base_hi);
        return addr[ADDR_W-1:ADDR_W-16] == base_hi;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on ties, or M1 always wins when FIXED_PRIO is set.
module rr_arb2
    import mem_bus_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    master_e last;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= M1_PDU;
        end else if (|gnt) begin
            last <= gnt[1] ? M1_PDU : M0_CPU;
        end
    end

    always_comb begin
        gnt = '0;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (FIXED_PRIO || last == M0_CPU) ? 2'b10 : 2'b01;
                default: gnt = '0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio_arbiter.sv
// Shares the DMEM/MMIO slave port between the CPU memory stage (M0) and the
// PDU debug port (M1); one grant per cycle, response one cycle after grant.
module dmem_mmio_arbiter
    import mem_bus_pkg::*;
#(
    parameter bit          FIXED_PRIO   = 1'b0,
    parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              cpu_stall,

    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,

    output logic [ADDR_W-1:0] mmio_addr,
    output logic              mmio_we,
    output logic [DATA_W-1:0] mmio_wdata,
    input  logic [DATA_W-1:0] mmio_rdata
);

    logic [1:0]        gnt;
    logic              gnt_any;
    master_e           gnt_id;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_we;
    logic              g_mmio;

    rsp_t              rsp;
    logic [DATA_W-1:0] mmio_q;
    logic [DATA_W-1:0] rsp_data;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk (clk),
        .rst (rst),
        .req ({m1_req, m0_req}),
        .gnt (gnt)
    );

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign gnt_any   = |gnt;
    assign gnt_id    = gnt[1] ? M1_PDU : M0_CPU;
    assign cpu_stall = m0_req & ~gnt[0];

    always_comb begin
        g_addr  = gnt[1] ? m1_addr  : m0_addr;
        g_wdata = gnt[1] ? m1_wdata : m0_wdata;
        g_we    = gnt[1] ? m1_we    : m0_we;
        g_mmio  = is_mmio(g_addr, MMIO_BASE_HI);
    end

    // Both slaves see the granted address; only the selected one may write.
    always_comb begin
        dmem_addr  = g_addr;
        mmio_addr  = g_addr;
        dmem_we    = gnt_any & g_we & ~g_mmio;
        mmio_we    = gnt_any & g_we &  g_mmio;
        dmem_wdata = g_mmio ? '0 : g_wdata;
        mmio_wdata = g_mmio ? g_wdata : '0;
    end

    // MMIO reads are combinational, so the word is captured here to line up
    // with the DMEM synchronous read one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp.v    <= 1'b0;
            rsp.id   <= M1_PDU;
            rsp.mmio <= 1'b0;
            rsp.we   <= 1'b0;
            mmio_q   <= '0;
        end else begin
            rsp.v    <= gnt_any;
            rsp.id   <= gnt_id;
            rsp.mmio <= g_mmio;
            rsp.we   <= g_we;
            if (gnt_any && !g_we && g_mmio) begin
                mmio_q <= mmio_rdata;
            end
        end
    end

    // rst also masks rvalid so a response pending at reset is dropped at once.
    always_comb begin
        rsp_data  = rsp.we ? '0 : (rsp.mmio ? mmio_q : dmem_rdata);
        m0_rvalid = rsp.v & ~rst & (rsp.id == M0_CPU);
        m1_rvalid = rsp.v & ~rst & (rsp.id == M1_PDU);
        m0_rdata  = m0_rvalid ? rsp_data : '0;
        m1_rdata  = m1_rvalid ? rsp_data : '0;
    end

endmodule
